uart_param_transceiver: RTL and testbench

//  Full-duplex UART with parametrised frame format (data bits, parity, stop bits) and an

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_if.sv | 23 ++
 rtl/uart_baud_gen.sv | 22 ++
 rtl/uart_param_transceiver.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_param_transceiver.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transceiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_HOLD
  } rx_state_e;

  function automatic int calc_div(int clk_freq, int baud, int oversample);
    int d;
    d = clk_freq / (baud * oversample);
    return (d < 1) ? 1 : d;
  endfunction

  // Words narrower than 9 bits are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_bit(parity_e mode, logic [8:0] data);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Valid/ready word interface between a host and the UART transceiver.
interface uart_if #(parameter int DATA_BITS = 8);
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_overrun;

  modport master (
    output tx_valid, tx_data, rx_ready,
    input  tx_ready, tx_busy, rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_overrun
  );

  modport slave (
    input  tx_valid, tx_data, rx_ready,
    output tx_ready, tx_busy, rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick: one-cycle pulse every DIV clocks.
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic os_tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in)            cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + CW'(1);
  end

  assign os_tick = (cnt == LAST);
endmodule

// File: rtl/uart_param_transceiver.sv
// Full-duplex UART with configurable frame format and 3-sample majority-vote receiver.
module uart_param_transceiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic   clk_in,
  input  logic   rst_in,
  uart_if.slave  bus,
  output logic   tx_out,
  input  logic   rx_in
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TCW = $clog2(2 * OVERSAMPLE);
  localparam int BCW = 4;
  localparam parity_e PAR_MODE = parity_e'(PARITY);
  localparam bit HAS_PAR = (PARITY != 0);
  localparam logic [TCW-1:0] BIT_END  = TCW'(OVERSAMPLE - 1);
  localparam logic [TCW-1:0] STOP_END = TCW'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [TCW-1:0] VOTE_0   = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] VOTE_1   = TCW'(OVERSAMPLE / 2);
  localparam logic [TCW-1:0] VOTE_2   = TCW'(OVERSAMPLE / 2 + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  logic os_tick;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .os_tick (os_tick)
  );

  // ---------------- transmitter ----------------
  tx_state_e            tx_state, tx_state_nxt;
  logic [TCW-1:0]       tx_tick, tx_tick_nxt;
  logic [BCW-1:0]       tx_bit, tx_bit_nxt;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_nxt;
  logic                 tx_par, tx_par_nxt, tx_line_nxt, tx_bit_end;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_state <= TX_IDLE;
      tx_tick  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_out   <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_tick  <= tx_tick_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      tx_par   <= tx_par_nxt;
      tx_out   <= tx_line_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_tick_nxt  = tx_tick;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_par_nxt   = tx_par;
    tx_bit_end   = os_tick && (tx_tick == BIT_END);
    if (os_tick && (tx_state inside {TX_START, TX_DATA, TX_PARITY, TX_STOP}))
      tx_tick_nxt = tx_tick + TCW'(1);
    case (tx_state)
      TX_IDLE: if (bus.tx_valid) begin
        tx_shift_nxt = bus.tx_data;
        tx_par_nxt   = parity_bit(PAR_MODE, 9'(bus.tx_data));
        tx_state_nxt = TX_WAIT;
      end
      TX_WAIT: if (os_tick) begin
        tx_state_nxt = TX_START;
        tx_tick_nxt  = '0;
      end
      TX_START: if (tx_bit_end) begin
        tx_state_nxt = TX_DATA;
        tx_tick_nxt  = '0;
        tx_bit_nxt   = '0;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_tick_nxt  = '0;
        tx_shift_nxt = tx_shift >> 1;
        if (tx_bit == LAST_BIT) tx_state_nxt = HAS_PAR ? TX_PARITY : TX_STOP;
        else                    tx_bit_nxt   = tx_bit + BCW'(1);
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_state_nxt = TX_STOP;
        tx_tick_nxt  = '0;
      end
      TX_STOP: if (os_tick && (tx_tick == STOP_END)) tx_state_nxt = TX_IDLE;
      default: tx_state_nxt = TX_IDLE;
    endcase
    // Line level is registered from the next state so tx_out never glitches.
    case (tx_state_nxt)
      TX_START:  tx_line_nxt = 1'b0;
      TX_DATA:   tx_line_nxt = tx_shift_nxt[0];
      TX_PARITY: tx_line_nxt = tx_par_nxt;
      default:   tx_line_nxt = 1'b1;
    endcase
  end

  assign bus.tx_ready = (tx_state == TX_IDLE);
  assign bus.tx_busy  = (tx_state != TX_IDLE);

  // ---------------- receiver ----------------
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  rx_state_e            rx_state, rx_state_nxt;
  logic [TCW-1:0]       rx_tick, rx_tick_nxt;
  logic [BCW-1:0]       rx_bit, rx_bit_nxt;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_nxt;
  logic [1:0]           rx_votes, rx_votes_nxt;
  logic                 rx_pbit, rx_pbit_nxt;
  logic                 rx_bit_end, rx_vote_pt, rx_vote, rx_done, rx_ferr_now, rx_perr_now;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_state <= RX_IDLE;
      rx_tick  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_votes <= '0;
      rx_pbit  <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_tick  <= rx_tick_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
      rx_votes <= rx_votes_nxt;
      rx_pbit  <= rx_pbit_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_tick_nxt  = rx_tick;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_votes_nxt = rx_votes;
    rx_pbit_nxt  = rx_pbit;
    rx_done      = 1'b0;
    rx_ferr_now  = 1'b0;
    rx_bit_end   = os_tick && (rx_tick == BIT_END);
    rx_vote_pt   = os_tick && (rx_tick == VOTE_2);
    rx_vote      = (rx_votes[0] & rx_votes[1]) | (rx_votes[0] & rx_sync) | (rx_votes[1] & rx_sync);
    if (os_tick && (rx_state != RX_IDLE) && (rx_state != RX_HOLD)) begin
      rx_tick_nxt = rx_bit_end ? '0 : rx_tick + TCW'(1);
      if (rx_tick == VOTE_0) rx_votes_nxt[0] = rx_sync;
      if (rx_tick == VOTE_1) rx_votes_nxt[1] = rx_sync;
    end
    case (rx_state)
      RX_IDLE: if (rx_prev && !rx_sync) begin
        rx_state_nxt = RX_START;
        rx_tick_nxt  = '0;
      end
      RX_START:
        if (rx_vote_pt && rx_vote) rx_state_nxt = RX_IDLE;
        else if (rx_bit_end) begin
          rx_state_nxt = RX_DATA;
          rx_bit_nxt   = '0;
        end
      RX_DATA: begin
        if (rx_vote_pt) rx_shift_nxt = {rx_vote, rx_shift[DATA_BITS-1:1]};
        if (rx_bit_end) begin
          if (rx_bit == LAST_BIT) rx_state_nxt = HAS_PAR ? RX_PARITY : RX_STOP;
          else                    rx_bit_nxt   = rx_bit + BCW'(1);
        end
      end
      RX_PARITY: begin
        if (rx_vote_pt) rx_pbit_nxt = rx_vote;
        if (rx_bit_end) rx_state_nxt = RX_STOP;
      end
      RX_STOP: if (rx_vote_pt) begin
        rx_done      = 1'b1;
        rx_ferr_now  = !rx_vote;
        // An all-zero word with a low stop bit is a break: wait for a full high bit.
        rx_state_nxt = (!rx_vote && (rx_shift == '0)) ? RX_HOLD : RX_IDLE;
        rx_tick_nxt  = '0;
      end
      RX_HOLD: if (os_tick) begin
        if (!rx_sync) rx_tick_nxt = '0;
        else if (rx_tick == BIT_END) begin
          rx_state_nxt = RX_IDLE;
          rx_tick_nxt  = '0;
        end else rx_tick_nxt = rx_tick + TCW'(1);
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
    rx_perr_now = HAS_PAR && (rx_pbit != parity_bit(PAR_MODE, 9'(rx_shift)));
  end

  logic                 rx_valid_q, rx_perr_q, rx_ferr_q, rx_ovr_q;
  logic [DATA_BITS-1:0] rx_data_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else if (rx_done) begin
      rx_valid_q <= 1'b1;
      rx_data_q  <= rx_shift;
      rx_perr_q  <= rx_perr_now;
      rx_ferr_q  <= rx_ferr_now;
      rx_ovr_q   <= rx_valid_q && !bus.rx_ready;
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end
  end

  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_data       = rx_data_q;
  assign bus.rx_parity_err = rx_perr_q;
  assign bus.rx_frame_err  = rx_ferr_q;
  assign bus.rx_overrun    = rx_ovr_q;
endmodule

// File: tb/tb_uart_param_transceiver.sv
// Directed bench: an 8N1 instance and a 7E2 instance, each with switchable loopback.
module tb_uart_param_transceiver;
  localparam int CLK_FREQ = 3_686_400;
  localparam int BAUD     = 115_200;
  localparam int OS       = 16;
  localparam int DIV      = 2;
  localparam int BIT      = OS * DIV;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in;
  logic tx_out_a, tx_out_b, line_a, line_b, loop_a, loop_b, rx_a, rx_b;
  assign rx_a = loop_a ? tx_out_a : line_a;
  assign rx_b = loop_b ? tx_out_b : line_b;

  uart_if #(.DATA_BITS(8)) bus_a ();
  uart_if #(.DATA_BITS(7)) bus_b ();

  uart_param_transceiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut_a (
    .clk_in (clk_in), .rst_in (rst_in), .bus (bus_a), .tx_out (tx_out_a), .rx_in (rx_a)
  );

  uart_param_transceiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7),
                           .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk_in (clk_in), .rst_in (rst_in), .bus (bus_b), .tx_out (tx_out_b), .rx_in (rx_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_rx(input bit which, input int max);
    int k = 0;
    while (((which ? bus_b.rx_valid : bus_a.rx_valid) !== 1'b1) && k < max) begin
      step(1);
      k++;
    end
    check(which ? "rx_b_valid_seen" : "rx_a_valid_seen",
          which ? bus_b.rx_valid : bus_a.rx_valid, 1);
  endtask

  task automatic wait_fall(input bit which, input int max);
    int k = 0;
    while (((which ? tx_out_b : tx_out_a) !== 1'b0) && k < max) begin
      step(1);
      k++;
    end
    check(which ? "tx_b_start_seen" : "tx_a_start_seen", which ? tx_out_b : tx_out_a, 0);
  endtask

  task automatic send_a(input logic [7:0] d);
    int k = 0;
    while (bus_a.tx_ready !== 1'b1 && k < 1000) begin
      step(1);
      k++;
    end
    check("tx_a_ready_before_send", bus_a.tx_ready, 1);
    bus_a.tx_data  = d;
    bus_a.tx_valid = 1'b1;
    step(1);
    bus_a.tx_valid = 1'b0;
  endtask

  task automatic consume(input bit which);
    if (which) bus_b.rx_ready = 1'b1; else bus_a.rx_ready = 1'b1;
    step(1);
    bus_a.rx_ready = 1'b0;
    bus_b.rx_ready = 1'b0;
  endtask

  task automatic drive_bits(input bit which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which) line_b = bits[i]; else line_a = bits[i];
      step(BIT);
    end
    if (which) line_b = 1'b1; else line_a = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fr;
    int n;
    rst_in = 1'b1;
    loop_a = 1'b1; loop_b = 1'b1; line_a = 1'b1; line_b = 1'b1;
    bus_a.tx_valid = 1'b0; bus_a.tx_data = '0; bus_a.rx_ready = 1'b0;
    bus_b.tx_valid = 1'b0; bus_b.tx_data = '0; bus_b.rx_ready = 1'b0;
    step(4);

    // Reset state
    check("rst_tx_out", tx_out_a, 1);
    check("rst_tx_ready", bus_a.tx_ready, 1);
    check("rst_tx_busy", bus_a.tx_busy, 0);
    check("rst_rx_valid", bus_a.rx_valid, 0);
    check("rst_rx_data", bus_a.rx_data, 0);
    check("rst_rx_flags", {bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_overrun}, 0);
    rst_in = 1'b0;
    step(2);

    // 1: 8N1 0xA5 waveform and loopback
    send_a(8'hA5);
    check("t1_ready_drop", bus_a.tx_ready, 0);
    check("t1_busy", bus_a.tx_busy, 1);
    wait_fall(0, 4 * DIV + 4);
    n = 0;
    while (tx_out_a === 1'b0 && n < 100) begin
      step(1);
      n++;
    end
    check("t1_start_len", n, BIT);
    fr = {6'b0, 1'b1, 8'hA5, 1'b0};
    step(BIT / 2);
    for (int i = 1; i < 10; i++) begin
      check($sformatf("t1_bit%0d", i), tx_out_a, fr[i]);
      if (i < 9) step(BIT);
    end
    check("t1_busy_in_stop", bus_a.tx_busy, 1);
    step(BIT / 2);
    check("t1_ready_after_stop", bus_a.tx_ready, 1);
    wait_rx(0, 200);
    check("t1_rx_data", bus_a.rx_data, 8'hA5);
    check("t1_rx_flags", {bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_overrun}, 0);
    consume(0);
    check("t1_consumed", bus_a.rx_valid, 0);

    // 2: 7E2 0x55, parity 0, two stop bits; then a flipped parity bit
    bus_b.tx_data  = 7'h55;
    bus_b.tx_valid = 1'b1;
    step(1);
    bus_b.tx_valid = 1'b0;
    wait_fall(1, 4 * DIV + 4);
    fr = {5'b0, 2'b11, 1'b0, 7'h55, 1'b0};
    step(BIT / 2);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("t2_bit%0d", i), tx_out_b, fr[i]);
      if (i < 10) step(BIT);
    end
    check("t2_busy_in_stop2", bus_b.tx_busy, 1);
    step(BIT / 2);
    check("t2_ready_after_stop2", bus_b.tx_ready, 1);
    wait_rx(1, 200);
    check("t2_rx_data", bus_b.rx_data, 7'h55);
    check("t2_rx_flags", {bus_b.rx_parity_err, bus_b.rx_frame_err, bus_b.rx_overrun}, 0);
    consume(1);
    loop_b = 1'b0;
    step(BIT);
    drive_bits(1, {5'b0, 2'b11, 1'b1, 7'h55, 1'b0}, 11);
    wait_rx(1, 200);
    check("t2_bad_par_data", bus_b.rx_data, 7'h55);
    check("t2_bad_par_perr", bus_b.rx_parity_err, 1);
    check("t2_bad_par_ferr", bus_b.rx_frame_err, 0);
    consume(1);

    // 3: short start glitch, then a single-tick glitch inside a data bit of 0x3C
    loop_a = 1'b0;
    step(BIT);
    line_a = 1'b0;
    step(OS / 4 * DIV);
    line_a = 1'b1;
    step(3 * BIT);
    check("t3_glitch_no_valid", bus_a.rx_valid, 0);
    fr = {6'b0, 1'b1, 8'h3C, 1'b0};
    for (int i = 0; i < 10; i++) begin
      line_a = fr[i];
      if (i == 3) begin
        step(18);
        line_a = ~fr[i];
        step(DIV);
        line_a = fr[i];
        step(BIT - 18 - DIV);
      end else step(BIT);
    end
    line_a = 1'b1;
    wait_rx(0, 200);
    check("t3_vote_data", bus_a.rx_data, 8'h3C);
    check("t3_vote_flags", {bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_overrun}, 0);
    consume(0);

    // 4: low stop bit on 0x81, then a two-word break, then 0x42
    drive_bits(0, {6'b0, 1'b0, 8'h81, 1'b0}, 10);
    wait_rx(0, 200);
    check("t4_ferr_data", bus_a.rx_data, 8'h81);
    check("t4_ferr_flag", bus_a.rx_frame_err, 1);
    check("t4_ferr_perr", bus_a.rx_parity_err, 0);
    consume(0);
    step(BIT);
    line_a = 1'b0;
    step(10 * BIT);
    check("t4_break_valid", bus_a.rx_valid, 1);
    check("t4_break_data", bus_a.rx_data, 0);
    check("t4_break_ferr", bus_a.rx_frame_err, 1);
    consume(0);
    step(10 * BIT);
    line_a = 1'b1;
    check("t4_break_single_word", bus_a.rx_valid, 0);
    step(2 * BIT);
    drive_bits(0, {6'b0, 1'b1, 8'h42, 1'b0}, 10);
    wait_rx(0, 200);
    check("t4_after_break_data", bus_a.rx_data, 8'h42);
    check("t4_after_break_flags", {bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_overrun}, 0);
    consume(0);

    // 5: two unread frames overrun; consume clears
    loop_a = 1'b1;
    step(BIT);
    send_a(8'h11);
    send_a(8'h22);
    n = 0;
    while (bus_a.tx_ready !== 1'b1 && n < 1000) begin
      step(1);
      n++;
    end
    step(4);
    check("t5_valid", bus_a.rx_valid, 1);
    check("t5_data", bus_a.rx_data, 8'h22);
    check("t5_overrun", bus_a.rx_overrun, 1);
    consume(0);
    check("t5_valid_cleared", bus_a.rx_valid, 0);
    check("t5_overrun_cleared", bus_a.rx_overrun, 0);

    // 6: reset during bit 4 with an unread word held
    send_a(8'h5A);
    wait_rx(0, 800);
    check("t6_prep_data", bus_a.rx_data, 8'h5A);
    step(BIT);
    send_a(8'hA5);
    wait_fall(0, 4 * DIV + 4);
    step(5 * BIT + BIT / 2);
    check("t6_busy_mid_frame", bus_a.tx_busy, 1);
    rst_in = 1'b1;
    step(1);
    check("t6_rst_tx_out", tx_out_a, 1);
    check("t6_rst_rx_valid", bus_a.rx_valid, 0);
    check("t6_rst_tx_ready", bus_a.tx_ready, 1);
    rst_in = 1'b0;
    step(BIT);
    send_a(8'h3C);
    wait_rx(0, 800);
    check("t6_after_rst_data", bus_a.rx_data, 8'h3C);
    check("t6_after_rst_flags", {bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_overrun}, 0);
    consume(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
